// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the MEM stage and the data-memory responder.
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// One-at-a-time RV32I byte/half/word data memory; rsp_valid LATENCY cycles after accept, held while rsp_ready is low.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned/unsupported accesses via rsp_err instead of aligning them down.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [7:0]            mem_q [2**ADDR_WIDTH];
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  req_ready_q, rsp_valid_q, busy_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic                  sup_c, mis_c, ok_c, err_c, commit_c;
  logic [ADDR_WIDTH-1:0] base_c;
  logic [3:0]            be_c;
  logic [31:0]           rd_word_c;
  logic [DATA_WIDTH-1:0] load_d;
  logic                  unused_addr;

  assign unused_addr = ^bus.req_addr[DATA_WIDTH-1:ADDR_WIDTH];
  assign commit_c    = (state_q == WAIT) && (cnt_q == 4'd0);

  always_comb begin
    // funct3[1:0]==11 is never a size; 1x0/1x1 with bit 1 set, or any store with bit 2 set, is unsupported
    sup_c  = (f3_q[1:0] != 2'b11) && !(f3_q[2] && (we_q || f3_q[1]));
    mis_c  = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
             ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    base_c = addr_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    ok_c  = sup_c && !mis_c;
    err_c = !ok_c;
`else
    ok_c  = sup_c;
    err_c = 1'b0;
    if (f3_q[1:0] == 2'b01) base_c[0] = 1'b0;
    if (f3_q[1:0] == 2'b10) base_c[1:0] = 2'b00;
`endif
    rd_word_c = {mem_q[base_c + ADDR_WIDTH'(3)], mem_q[base_c + ADDR_WIDTH'(2)],
                 mem_q[base_c + ADDR_WIDTH'(1)], mem_q[base_c]};
    be_c = 4'b0000;
    if (ok_c && we_q) begin
      case (f3_q[1:0])
        2'b00:   be_c = 4'b0001;
        2'b01:   be_c = 4'b0011;
        2'b10:   be_c = 4'b1111;
        default: be_c = 4'b0000;
      endcase
    end
    load_d = '0;
    if (ok_c && !we_q) begin
      case (f3_q)
        3'b000:  load_d = {{(DATA_WIDTH-8){rd_word_c[7]}}, rd_word_c[7:0]};
        3'b001:  load_d = {{(DATA_WIDTH-16){rd_word_c[15]}}, rd_word_c[15:0]};
        3'b010:  load_d = DATA_WIDTH'(rd_word_c);
        3'b100:  load_d = {{(DATA_WIDTH-8){1'b0}}, rd_word_c[7:0]};
        3'b101:  load_d = {{(DATA_WIDTH-16){1'b0}}, rd_word_c[15:0]};
        default: load_d = '0;
      endcase
    end
  end

  // Array has no reset; a reset on the commit edge suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && commit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem_q[base_c + ADDR_WIDTH'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            f3_q        <= bus.req_funct3;
            addr_q      <= bus.req_addr[ADDR_WIDTH-1:0];
            wdata_q     <= bus.req_wdata;
            cnt_q       <= CNT_INIT;
            state_q     <= WAIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_d;
            rsp_err_q   <= err_c;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expected responses queued at request time, popped on rsp_valid.
module tb_dmem_responder;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [32:0] sb_q [$];

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  dmem_responder_if #(.DATA_WIDTH(32)) bus ();

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, hold rsp_ready low for 'hold' cycles once the response is up
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_d, input logic exp_e, input int hold);
    int t;
    int lat;
    logic [32:0] e;
    logic [31:0] held;
    sb_q.push_back({exp_e, exp_d});
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.rsp_ready  = (hold == 0);
    t = 0;
    while (!bus.req_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({tag, ".busy_rise"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({tag, ".latency"}, 32'(lat), 32'(LATENCY));
    e = sb_q.pop_front();
    chk({tag, ".rdata"}, bus.rsp_rdata, e[31:0]);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(e[32]));
    held = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      // A competing request must be ignored while the response is pending
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr  = addr;
      bus.req_wdata = 32'h0BAD_0BAD;
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, bus.rsp_rdata, held);
      chk({tag, ".hold_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, ".hold_req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".idle_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".idle_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    xact("sw_word", 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    xact("lw_word", 1'b0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    xact("sw_fill20", 1'b1, 3'b010, 32'h020, 32'h11223344, 32'h0, 1'b0, 0);
    xact("sb_21", 1'b1, 3'b000, 32'h021, 32'hAAAAAA80, 32'h0, 1'b0, 0);
    xact("lb_21", 1'b0, 3'b000, 32'h021, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    xact("lbu_21", 1'b0, 3'b100, 32'h021, 32'h0, 32'h00000080, 1'b0, 0);
    xact("lw_20", 1'b0, 3'b010, 32'h020, 32'h0, 32'h11228044, 1'b0, 0);

    xact("sw_fill30", 1'b1, 3'b010, 32'h030, 32'h00000000, 32'h0, 1'b0, 0);
    xact("sh_32", 1'b1, 3'b001, 32'h032, 32'hBBBB8001, 32'h0, 1'b0, 0);
    xact("lh_32", 1'b0, 3'b001, 32'h032, 32'h0, 32'hFFFF8001, 1'b0, 0);
    xact("lhu_32", 1'b0, 3'b101, 32'h032, 32'h0, 32'h00008001, 1'b0, 0);
    xact("lw_30", 1'b0, 3'b010, 32'h030, 32'h0, 32'h80010000, 1'b0, 0);

    xact("bp_lw", 1'b0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    xact("bp_after", 1'b0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Store aborted by reset on its commit edge leaves old contents
    xact("sw_40", 1'b1, 3'b010, 32'h040, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h040;
    bus.req_wdata  = 32'h12345678;
    chk("abort.req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (LATENCY - 1) @(posedge clk);
    #1;
    chk("abort.busy_wait", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.req_ready_rst", 32'(bus.req_ready), 32'd1);
    chk("abort.rsp_valid_rst", 32'(bus.rsp_valid), 32'd0);
    chk("abort.busy_rst", 32'(bus.busy), 32'd0);
    chk("abort.rdata_rst", bus.rsp_rdata, 32'd0);
    xact("lw_40_kept", 1'b0, 3'b010, 32'h040, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    xact("lw_42_mis", 1'b0, 3'b010, 32'h042, 32'h0, TRAP ? 32'h0 : 32'hCAFEF00D, TRAP, 0);
    xact("lh_33_mis", 1'b0, 3'b001, 32'h033, 32'h0, TRAP ? 32'h0 : 32'hFFFF8001, TRAP, 0);
    xact("lw_1040_alias", 1'b0, 3'b010, 32'h1040, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    xact("sw_1044_alias", 1'b1, 3'b010, 32'h1044, 32'h55667788, 32'h0, 1'b0, 0);
    xact("lw_44", 1'b0, 3'b010, 32'h044, 32'h0, 32'h55667788, 1'b0, 0);
    xact("ld_bad_f3", 1'b0, 3'b011, 32'h040, 32'h0, 32'h0, TRAP, 0);
    xact("st_bad_f3", 1'b1, 3'b101, 32'h040, 32'hFFFFFFFF, 32'h0, TRAP, 0);
    xact("lw_40_after", 1'b0, 3'b010, 32'h040, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the memory-side end of the MEM-stage load/store interface. Accepts one request at a time from the pipeline over a valid/ready handshake and performs an RV32I byte, halfword or word access selected by funct3, with configurable latency. Returns load data sign- or zero-extended on a valid/ready response channel. Drives a busy flag that the hazard unit uses to stall the pipeline.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address bus width.
- ADDR_WIDTH, 12, byte-address bits actually decoded; the array is 2^ADDR_WIDTH bytes.
- LATENCY, 2, cycles from request accept to response valid; legal range is 1 to 15.

Ports:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous, active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, responder can accept a request.
- req_we, in, 1, 1 = store, 0 = load.
- req_funct3, in, 3, access size and sign (RV32I load/store funct3).
- req_addr, in, DATA_WIDTH, byte address.
- req_wdata, in, DATA_WIDTH, store data; low bytes are used for SB/SH.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, consumer accepts the response.
- rsp_rdata, out, DATA_WIDTH, extended load data; 0 for stores.
- rsp_err, out, 1, access error flag (see Configuration).
- busy, out, 1, high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid is high: latch we, funct3, addr[ADDR_WIDTH-1:0] and wdata; load the counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready = 0.
  - If the counter is nonzero, decrement it.
  - If the counter is 0, commit the access at this edge and go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_valid && rsp_ready, go to IDLE.
- Only one request is outstanding at a time. No request is accepted in WAIT or RESP.
- Byte order is little-endian.
- Loads:
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the halfword.
- Stores:
  - 000 SB: write 1 byte at addr.
  - 001 SH: write 2 bytes.
  - 010 SW: write 4 bytes.
  - Bytes outside the access are not modified.
- Unsupported funct3 (loads 011/110/111, stores other than 000/001/010): no write, rsp_rdata = 0, response still issued.
- Address bits above ADDR_WIDTH are ignored, so addresses wrap modulo 2^ADDR_WIDTH.
- Without the macro, misaligned halfword/word accesses are aligned down: low bits are forced to 0.
- Array contents are not reset.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, counter 0.
- Reset in WAIT aborts the access: no write occurs. Reset in RESP drops the response.

## Timing
- Request accepted at rising edge N (req_valid && req_ready).
- Memory write or read capture happens at edge N+LATENCY.
- rsp_valid is high from edge N+LATENCY. rsp_rdata is registered, with no combinational path from the array.
- With rsp_ready held high, the response handshake completes at edge N+LATENCY+1 and req_ready is high again in the following cycle.
- The next request can be accepted at edge N+LATENCY+2 at the earliest.
- busy rises at edge N and falls at the response-handshake edge.
- rsp_ready low in RESP holds the state indefinitely, with outputs unchanged.
- req_valid asserted during WAIT/RESP is ignored. The initiator holds its request until req_ready is seen.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A halfword access with addr[0] = 1 is misaligned.
  - A word access with addr[1:0] != 0 is misaligned.
  - Unsupported funct3 is an error.
  - Any misaligned or error access performs no write, returns rsp_rdata 0, and raises rsp_err = 1 with that response.
- DMEM_MISALIGN_TRAP_EN undefined: aligns down as above, and rsp_err is tied to 0.

## Test plan
- Word round trip (LATENCY = 2): SW 0xDEADBEEF to 0x010, then LW 0x010 -> rsp_rdata 0xDEADBEEF, rsp_valid exactly 2 cycles after each accept.
- Signed bytes: SB 0x80 to 0x021, then LB 0x021 -> 0xFFFFFF80; LBU 0x021 -> 0x00000080; LW 0x020 -> byte 1 = 0x80, other bytes unchanged.
- Halfword: SH 0x8001 to 0x032, then LH 0x032 -> 0xFFFF8001; LHU 0x032 -> 0x00008001.
- Backpressure: LW with rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable, busy = 1, req_ready = 0, a second req_valid is ignored; rsp_ready = 1 -> IDLE next cycle.
- Reset mid-op: SW 0x12345678 to 0x040, rst asserted in the WAIT cycle -> all outputs at reset values; LW 0x040 -> previous contents.
- Misalignment: LW 0x042
  - With DMEM_MISALIGN_TRAP_EN: rsp_err = 1, rsp_rdata 0.
  - Without it: returns the word at 0x040, rsp_err = 0.
  - Address 0x1040 with ADDR_WIDTH 12 aliases 0x040.
